// File: rtl/matrix_pair_loader_if.sv
// rtl/matrix_pair_loader_if.sv - element stream in, packed matrix pair out, plus load control
interface matrix_pair_loader_if #(
    parameter int ELEM_W = 4
);
    localparam int MAT_W = 4 * ELEM_W;

    logic              flush;
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [MAT_W-1:0]  a_mat;
    logic [MAT_W-1:0]  b_mat;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        elem_idx;

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, a_mat, b_mat, out_valid, elem_idx
    );

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, a_mat, b_mat, out_valid, elem_idx
    );
endinterface

// File: rtl/matrix_pair_loader.sv
// rtl/matrix_pair_loader.sv - assembles two row-major 2x2 matrices from an element stream
module matrix_pair_loader #(
    parameter  int ELEM_W = 4,
    localparam int MAT_W  = 4 * ELEM_W
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_pair_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         idx;
    logic [MAT_W-1:0]   a_word;
    logic [MAT_W-1:0]   b_word;
    logic               out_valid;

    // Slot 0 ([0][0]) lives in the MSBs, slot 3 ([1][1]) in the LSBs.
    function automatic int slot_lsb(input logic [1:0] i);
        return (3 - int'(i)) * ELEM_W;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_A;
            idx       <= 2'd0;
            a_word    <= '0;
            b_word    <= '0;
            out_valid <= 1'b0;
        end else if (bus.flush) begin
            state     <= LOAD_A;
            idx       <= 2'd0;
            a_word    <= '0;
            b_word    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (bus.in_valid) begin
                        a_word[slot_lsb(idx) +: ELEM_W] <= bus.in_data;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (bus.in_valid) begin
                        b_word[slot_lsb(idx) +: ELEM_W] <= bus.in_data;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Matrices stay frozen here; they are not cleared on the way back.
                    if (bus.out_ready) begin
                        state     <= LOAD_A;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD_A;
                    idx       <= 2'd0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state != HOLD);
    assign bus.a_mat     = a_word;
    assign bus.b_mat     = b_word;
    assign bus.out_valid = out_valid;
    assign bus.elem_idx  = idx;
endmodule

// File: tb/tb_matrix_pair_loader.sv
// tb/tb_matrix_pair_loader.sv - randomized scoreboard bench for matrix_pair_loader
module tb_matrix_pair_loader;
    logic clk;
    logic rst;

    matrix_pair_loader_if #(.ELEM_W(4)) bus ();

    matrix_pair_loader #(.ELEM_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    pair_t       exp_q[$];
    logic [3:0]  elems[$];
    int          m_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        expect_zero = 1'b0;

    // Reference model: a pair is just the first eight accepted elements, in order.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            elems.delete();
            exp_q.delete();
        end else if (bus.flush) begin
            m_cnt = 0;
            elems.delete();
        end else if (m_cnt == 8) begin
            if (bus.out_ready) begin
                m_cnt = 0;
                elems.delete();
            end
        end else if (bus.in_valid) begin
            elems.push_back(bus.in_data);
            m_cnt++;
            if (m_cnt == 8)
                exp_q.push_back('{a: {elems[0], elems[1], elems[2], elems[3]},
                                  b: {elems[4], elems[5], elems[6], elems[7]}});
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_a_mat", 32'(bus.a_mat), 32'd0);
            chk("rst_b_mat", 32'(bus.b_mat), 32'd0);
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_cnt < 8));
            chk("out_valid", 32'(bus.out_valid), 32'(m_cnt == 8));
            chk("elem_idx", 32'(bus.elem_idx), 32'(m_cnt % 4));
            if (expect_zero) begin
                chk("flush_a_mat", 32'(bus.a_mat), 32'd0);
                chk("flush_b_mat", 32'(bus.b_mat), 32'd0);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("pair_expected", 32'd0, 32'd1);
                end else begin
                    chk("a_mat", 32'(bus.a_mat), 32'(exp_q[0].a));
                    chk("b_mat", 32'(bus.b_mat), 32'(exp_q[0].b));
                    if (bus.out_ready || bus.flush)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] d, input logic r, input logic f);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_zero_check();
        expect_zero = 1'b1;
        #4;
        expect_zero = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h7;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Partial load aborted by a mid-cycle reset with in_valid high.
        for (int i = 1; i <= 3; i++) drive(1'b1, 4'(i), 1'b1, 1'b0);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;

        // Back-to-back pair 1..8.
        for (int i = 1; i <= 8; i++) drive(1'b1, 4'(i), 1'b1, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b0);

        // Backpressure with F offered during HOLD; F then becomes A00.
        for (int i = 1; i <= 8; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
        repeat (5) drive(1'b1, 4'hF, 1'b0, 1'b0);
        drive(1'b1, 4'hF, 1'b1, 1'b0);
        drive(1'b1, 4'hF, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) drive(1'b1, 4'(i), 1'b1, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b0);

        // Bubbles between every element.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'(i), 1'b1, 1'b0);
            drive(1'b0, 4'hE, 1'b1, 1'b0);
        end

        // Flush in the middle of B, colliding with an input transfer.
        drive(1'b1, 4'h9, 1'b1, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 1'b0);
        drive(1'b1, 4'hB, 1'b1, 1'b0);
        drive(1'b1, 4'hC, 1'b1, 1'b0);
        drive(1'b1, 4'h1, 1'b1, 1'b0);
        drive(1'b1, 4'h2, 1'b1, 1'b0);
        drive(1'b1, 4'h5, 1'b1, 1'b1);
        pulse_zero_check();
        for (int i = 0; i < 8; i++) drive(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b0);

        // Flush in HOLD together with out_ready.
        for (int i = 0; i < 8; i++) drive(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        pulse_zero_check();

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/matrix_pair_loader.md
# matrix_pair_loader

- Upstream feeder for the 2x2 matrix adder.
- Accepts a serial stream of matrix elements over a valid/ready handshake and assembles two 2x2 matrices, A then B, in row-major order.
- Presents both matrices as packed, registered words that stay stable under an output valid/ready handshake, ready for the combinational adder stage.

## Interface

Parameters:
- ELEM_W, 4: width of one matrix element in bits.
- MAT_W, 4*ELEM_W (16 at default): packed width of one 2x2 matrix; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; discards the partial or held pair.
- in_data  input  ELEM_W  element value.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an element this cycle.
- a_mat  output  MAT_W  packed matrix A = {A00, A01, A10, A11}, A00 in the MSBs.
- b_mat  output  MAT_W  packed matrix B, same packing as a_mat.
- out_valid  output  1  a_mat/b_mat hold a complete pair.
- out_ready  input  1  downstream consumes the pair.
- elem_idx  output  2  index of the next element slot within the matrix being loaded (0..3).

## Operation

- State machine with three states: LOAD_A, LOAD_B, HOLD.
- Input transfer occurs on a cycle with in_valid & in_ready.
- in_ready = 1 in LOAD_A and LOAD_B, 0 in HOLD. It is decoded from state only and never depends on in_valid.
- Element order is row-major. elem_idx 0 → [0][0] (bits MAT_W-1 : MAT_W-ELEM_W), 1 → [0][1], 2 → [1][0], 3 → [1][1] (bits ELEM_W-1:0).
- LOAD_A: each transfer writes in_data into the a_mat slot selected by elem_idx, then increments elem_idx. On the transfer at idx 3: elem_idx wraps to 0 and the state moves to LOAD_B.
- LOAD_B: same behaviour, writing into b_mat. On the transfer at idx 3: elem_idx wraps to 0, the state moves to HOLD and out_valid is set.
- HOLD: out_valid = 1; a_mat and b_mat are frozen. On out_valid & out_ready: out_valid clears and the state returns to LOAD_A.
- Outputs are not cleared on a return to LOAD_A. a_mat/b_mat keep their old contents until each slot is overwritten; downstream samples them only while out_valid = 1.
- Flush (synchronous, highest priority after rst):
  - Sets state LOAD_A, elem_idx 0, out_valid 0, a_mat 0, b_mat 0.
  - Any input transfer or output handshake in the same cycle is ignored.
- Reset (asynchronous): state LOAD_A, elem_idx 0, a_mat 0, b_mat 0, out_valid 0. in_ready reads 1 while rst is asserted and after it deasserts.
- No arithmetic is performed; element values pass through bit-exact.

## Timing

- Input throughput: one element per cycle. A pair takes 8 accepted elements.
- Latency: out_valid rises on the clock edge that accepts the 8th element, i.e. it is visible in the following cycle.
- In that same following cycle in_ready is 0.
- Minimum period from the first element of one pair to the first element of the next is 9 cycles, with out_ready held at 1:
  - 8 load cycles.
  - 1 HOLD cycle. in_ready returns to 1 in the cycle after the out handshake.
- No bypass: elements offered during HOLD are not accepted. The upstream producer must hold in_data/in_valid until in_ready = 1.
- Output rules: while out_valid = 1, a_mat, b_mat and out_valid do not change until an out handshake, flush or rst.
- An out_ready asserted while out_valid = 0 has no effect.
- A rst assertion mid-load or in HOLD aborts immediately. The partial pair is lost and there is no recovery.
- in_valid low for any number of cycles during a load stalls the load. elem_idx and the partial contents are held.

## Test plan

- Reset/idle: assert rst mid-cycle with in_valid = 1 → a_mat = b_mat = 0, out_valid = 0 and in_ready = 1 immediately; elem_idx = 0 after release.
- Back-to-back pair: stream 1,2,3,4,5,6,7,8 (ELEM_W = 4) with in_valid = 1 and out_ready = 1 → a_mat = 16'h1234 and b_mat = 16'h5678 with out_valid = 1 for exactly 1 cycle. That cycle is the one after the 8th accept; in_ready is 0 in it and 1 in the next.
- Backpressure: complete a pair with out_ready = 0 for 5 cycles while in_valid = 1 with data F → in_ready = 0, outputs frozen at 1234/5678, no element accepted. Raise out_ready → next pair loads F as A00.
- Bubbles: 8 elements with in_valid toggling 1,0,1,0… → same packed result as the back-to-back pair; elem_idx is held across the gaps.
- Flush mid-B: load A = 9ABC, then 2 elements of B, then pulse flush together with in_valid → that element is dropped, state returns to LOAD_A, a_mat = 0. The next 8 elements form a correct pair.
- Flush in HOLD with out_ready = 1 the same cycle → no handshake is counted, out_valid = 0 and outputs = 0 on the next cycle.
